// File: rtl/fnd_scan_ctrl.sv
// N-digit multiplexed seven-segment scan controller: frame snapshot, dead time, LZ suppression, blink.
// Outputs registered one cycle after the scan state; free-running, no backpressure.
module fnd_scan_ctrl #(
    parameter int NUM_DIG      = 6,
    parameter int SCAN_DIV     = 5000,
    parameter int DEAD_CYC     = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int SEG_ACT_LOW  = 0,
    parameter int ENB_ACT_LOW  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic [4*NUM_DIG-1:0]   i_digits,
    input  logic [NUM_DIG-1:0]     i_dp,
    input  logic                   i_lz_sup,
    input  logic [NUM_DIG-1:0]     i_blink_mask,
    output logic [6:0]             o_seg,
    output logic                   o_seg_dp,
    output logic [NUM_DIG-1:0]     o_seg_enb,
    output logic                   o_frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIG);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ON  = CW'(DEAD_CYC);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIG - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);
    localparam logic SEG_INV = (SEG_ACT_LOW != 0);
    localparam logic ENB_INV = (ENB_ACT_LOW != 0);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [BW-1:0]          blk_cnt;
    logic                   blk_ph;
    logic [4*NUM_DIG-1:0]   sh_digits;
    logic [NUM_DIG-1:0]     sh_dp;
    logic [NUM_DIG-1:0]     sh_mask;
    logic                   sh_lz;
    logic                   sh_ph;
    logic                   frame_load;
    logic [NUM_DIG-1:0]     sup;
    logic                   zero_run;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_mask;
    logic                   cur_sup;
    logic                   slot_on;
    logic [6:0]             seg_nxt;
    logic                   dp_nxt;
    logic [NUM_DIG-1:0]     enb_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1110011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    assign frame_load = i_en && (idx == '0) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            blk_cnt <= '0;
            blk_ph  <= 1'b0;
        end else if (!i_en) begin
            cnt     <= '0;
            idx     <= '0;
            blk_cnt <= '0;
            blk_ph  <= 1'b0;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_load) begin
                if (blk_cnt == BLK_MAX) begin
                    blk_cnt <= '0;
                    blk_ph  <= ~blk_ph;
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end
        end
    end

    // The blink phase is snapshotted with the digits so a whole frame shares one phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_mask   <= '0;
            sh_lz     <= 1'b0;
            sh_ph     <= 1'b0;
        end else if (frame_load) begin
            sh_digits <= i_digits;
            sh_dp     <= i_dp;
            sh_mask   <= i_blink_mask;
            sh_lz     <= i_lz_sup;
            sh_ph     <= blk_ph;
        end
    end

    always_comb begin
        sup      = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIG - 1; k >= 1; k--) begin
            zero_run = zero_run && (sh_digits[4*k +: 4] == 4'd0);
            sup[k]   = sh_lz && zero_run;
        end
    end

    always_comb begin
        cur_nib  = 4'd0;
        cur_dp   = 1'b0;
        cur_mask = 1'b0;
        cur_sup  = 1'b0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (idx == IW'(k)) begin
                cur_nib  = sh_digits[4*k +: 4];
                cur_dp   = sh_dp[k];
                cur_mask = sh_mask[k];
                cur_sup  = sup[k];
            end
        end
        slot_on = i_en && (cnt >= CNT_ON);
        seg_nxt = '0;
        dp_nxt  = 1'b0;
        enb_nxt = '0;
        if (slot_on) begin
            enb_nxt = NUM_DIG'(1) << idx;
            if (!(sh_ph && cur_mask)) begin
                seg_nxt = cur_sup ? 7'd0 : seg_decode(cur_nib);
                dp_nxt  = cur_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_seg         <= {7{SEG_INV}};
            o_seg_dp      <= SEG_INV;
            o_seg_enb     <= {NUM_DIG{ENB_INV}};
            o_frame_start <= 1'b0;
        end else begin
            o_seg         <= seg_nxt ^ {7{SEG_INV}};
            o_seg_dp      <= dp_nxt ^ SEG_INV;
            o_seg_enb     <= enb_nxt ^ {NUM_DIG{ENB_INV}};
            o_frame_start <= frame_load;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
module tb_fnd_scan_ctrl;
    localparam int ND = 4;
    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BF = 2;
    localparam int FR = ND * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_en = 1'b0;
    logic i_lz_sup = 1'b0;
    logic [4*ND-1:0] i_digits = '0;
    logic [ND-1:0] i_dp = '0;
    logic [ND-1:0] i_blink_mask = '0;
    logic [6:0] seg_a, seg_b;
    logic dp_a, dp_b, fs_a, fs_b;
    logic [ND-1:0] enb_a, enb_b;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.NUM_DIG(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_FRAMES(BF),
                    .SEG_ACT_LOW(0), .ENB_ACT_LOW(1)) u_a (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_digits(i_digits), .i_dp(i_dp),
        .i_lz_sup(i_lz_sup), .i_blink_mask(i_blink_mask), .o_seg(seg_a),
        .o_seg_dp(dp_a), .o_seg_enb(enb_a), .o_frame_start(fs_a));

    fnd_scan_ctrl #(.NUM_DIG(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_FRAMES(BF),
                    .SEG_ACT_LOW(1), .ENB_ACT_LOW(0)) u_b (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_digits(i_digits), .i_dp(i_dp),
        .i_lz_sup(i_lz_sup), .i_blink_mask(i_blink_mask), .o_seg(seg_b),
        .o_seg_dp(dp_b), .o_seg_enb(enb_b), .o_frame_start(fs_b));

    int checks = 0;
    int failures = 0;

    // Reference model: n = enabled cycles since (re)start; frame snapshot held in arrays.
    int n, pn;
    logic [3:0] sd [ND];
    logic [ND-1:0] s_dp, s_mask;
    logic s_lz, s_ph;
    logic [6:0] e_seg;
    logic e_dp, e_fs;
    logic [ND-1:0] e_enb;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return tbl[v];
    endfunction

    function automatic logic [25:0] ovec();
        return {seg_a, dp_a, enb_a, fs_a, seg_b, dp_b, enb_b, fs_b};
    endfunction

    function automatic logic [25:0] evec();
        return {e_seg, e_dp, ~e_enb, e_fs, ~e_seg, ~e_dp, e_enb, e_fs};
    endfunction

    task automatic model_reset();
        n = 0;
        pn = 0;
        for (int k = 0; k < ND; k++) sd[k] = 4'd0;
        s_dp = '0; s_mask = '0; s_lz = 1'b0; s_ph = 1'b0;
        e_seg = '0; e_dp = 1'b0; e_fs = 1'b0; e_enb = '0;
    endtask

    task automatic tick();
        int c, d;
        logic blank_lz;
        e_seg = '0; e_dp = 1'b0; e_enb = '0; e_fs = 1'b0;
        pn = n;
        if (i_en) begin
            c = n % SD;
            d = (n / SD) % ND;
            e_fs = (n % FR == 0);
            if (c >= DC) begin
                e_enb[d] = 1'b1;
                blank_lz = s_lz && (d > 0);
                for (int j = d; j < ND; j++) if (sd[j] != 4'd0) blank_lz = 1'b0;
                e_seg = blank_lz ? 7'd0 : glyph(sd[d]);
                e_dp = s_dp[d];
                if (s_ph && s_mask[d]) begin
                    e_seg = '0;
                    e_dp = 1'b0;
                end
            end
            if (n % FR == 0) begin
                for (int k = 0; k < ND; k++) sd[k] = i_digits[4*k +: 4];
                s_dp = i_dp; s_mask = i_blink_mask; s_lz = i_lz_sup;
                s_ph = ((n / FR) / BF) % 2 == 1;
            end
            n = n + 1;
        end else begin
            n = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (seg_a !== 7'h00) begin failures++; $display("FAIL reset_seg_a got=%b exp=0000000", seg_a); end
        checks++; if (seg_b !== 7'h7F) begin failures++; $display("FAIL reset_seg_b got=%b exp=1111111", seg_b); end
        checks++; if (enb_a !== 4'hF) begin failures++; $display("FAIL reset_enb_a got=%b exp=1111", enb_a); end
        checks++; if (enb_b !== 4'h0) begin failures++; $display("FAIL reset_enb_b got=%b exp=0000", enb_b); end
        checks++; if ({dp_a, dp_b} !== 2'b01) begin failures++; $display("FAIL reset_dp got=%b exp=01", {dp_a, dp_b}); end
        checks++; if ({fs_a, fs_b} !== 2'b00) begin failures++; $display("FAIL reset_fs got=%b exp=00", {fs_a, fs_b}); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        int fs_cnt = 0;
        i_digits = 16'h3210; i_dp = '0; i_lz_sup = 1'b0; i_blink_mask = '0;
        i_en = 1'b1;
        for (int i = 0; i < 3 * FR; i++) begin
            tick();
            fs_cnt += int'(fs_a);
            checks++;
            if (ovec() !== evec()) begin failures++; $display("FAIL basic n=%0d got=%h exp=%h", pn, ovec(), evec()); end
            if (pn == DC) begin
                checks++;
                if ({seg_a, enb_a} !== {7'b1111110, 4'b1110}) begin failures++; $display("FAIL basic_d0 got=%b/%b exp=1111110/1110", seg_a, enb_a); end
            end
            if (pn == 3 * SD + DC) begin
                checks++;
                if ({seg_a, enb_a} !== {7'b1111001, 4'b0111}) begin failures++; $display("FAIL basic_d3 got=%b/%b exp=1111001/0111", seg_a, enb_a); end
            end
        end
        checks++;
        if (fs_cnt != 3) begin failures++; $display("FAIL basic_frames got=%0d exp=3", fs_cnt); end
    endtask

    task automatic test_midframe();
        logic [31:0] r;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FR; i++) begin
                if (n % FR == 10) begin
                    r = $urandom;
                    i_digits = r[15:0];
                    i_dp = r[19:16];
                end
                tick();
                checks++;
                if (ovec() !== evec()) begin failures++; $display("FAIL midframe n=%0d got=%h exp=%h", pn, ovec(), evec()); end
            end
        end
    endtask

    task automatic test_lz();
        logic [31:0] r;
        i_lz_sup = 1'b1; i_digits = 16'h0007; i_dp = 4'b0100;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            checks++;
            if (ovec() !== evec()) begin failures++; $display("FAIL lz n=%0d got=%h exp=%h", pn, ovec(), evec()); end
            if (s_dp == 4'b0100 && s_lz && pn % FR == 2 * SD + DC) begin
                checks++;
                if ({seg_a, dp_a} !== {7'd0, 1'b1}) begin failures++; $display("FAIL lz_d2 got=%b/%b exp=0000000/1", seg_a, dp_a); end
            end
            if (s_dp == 4'b0100 && s_lz && pn % FR == DC) begin
                checks++;
                if (seg_a !== 7'b1110000) begin failures++; $display("FAIL lz_d0 got=%b exp=1110000", seg_a); end
            end
        end
        i_digits = 16'h0000; i_dp = 4'b0000;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            checks++;
            if (ovec() !== evec()) begin failures++; $display("FAIL lz_zero n=%0d got=%h exp=%h", pn, ovec(), evec()); end
        end
        for (int f = 0; f < 6; f++) begin
            r = $urandom;
            i_digits = r[15:0] >> (4 * $urandom_range(0, 4));
            i_dp = r[19:16];
            for (int i = 0; i < FR; i++) begin
                tick();
                checks++;
                if (ovec() !== evec()) begin failures++; $display("FAIL lz_rand n=%0d got=%h exp=%h", pn, ovec(), evec()); end
            end
        end
        i_lz_sup = 1'b0;
    endtask

    task automatic test_blink();
        i_en = 1'b0;
        tick(); tick();
        i_digits = 16'h1284; i_dp = 4'b0010; i_blink_mask = 4'b0010; i_en = 1'b1;
        for (int i = 0; i < 6 * FR; i++) begin
            tick();
            checks++;
            if (ovec() !== evec()) begin failures++; $display("FAIL blink n=%0d got=%h exp=%h", pn, ovec(), evec()); end
            if (pn % FR == SD + DC) begin
                checks++;
                if (((pn / FR == 2 || pn / FR == 3) ? {7'd0, 1'b0, 4'b1101} : {7'h7F, 1'b1, 4'b1101}) !== {seg_a, dp_a, enb_a}) begin
                    failures++;
                    $display("FAIL blink_d1 frame=%0d got=%b/%b/%b", pn / FR, seg_a, dp_a, enb_a);
                end
            end
        end
        i_blink_mask = '0;
    endtask

    task automatic test_en_drop();
        while (n % FR != 13) tick();
        i_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ovec() !== evec()) begin failures++; $display("FAIL en_drop n=%0d got=%h exp=%h", pn, ovec(), evec()); end
            if (i == 0) begin
                checks++;
                if ({seg_a, enb_a} !== {7'd0, 4'hF}) begin failures++; $display("FAIL en_drop_idle got=%b/%b exp=0000000/1111", seg_a, enb_a); end
            end
        end
        i_en = 1'b1;
        tick();
        checks++;
        if (fs_a !== 1'b1) begin failures++; $display("FAIL en_restart_fs got=%b exp=1", fs_a); end
        for (int i = 0; i < FR; i++) begin
            tick();
            checks++;
            if (ovec() !== evec()) begin failures++; $display("FAIL en_restart n=%0d got=%h exp=%h", pn, ovec(), evec()); end
        end
    endtask

    task automatic test_async_reset();
        while (n % FR != 13) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({seg_a, dp_a, enb_a, fs_a, seg_b, dp_b, enb_b} !== {7'd0, 1'b0, 4'hF, 1'b0, 7'h7F, 1'b1, 4'h0}) begin
            failures++;
            $display("FAIL async_reset got=%b_%b_%b_%b_%b_%b_%b", seg_a, dp_a, enb_a, fs_a, seg_b, dp_b, enb_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        i_digits = 16'h9A5C;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            checks++;
            if (ovec() !== evec()) begin failures++; $display("FAIL post_reset n=%0d got=%h exp=%h", pn, ovec(), evec()); end
            if (i == 0) begin
                checks++;
                if (fs_a !== 1'b1) begin failures++; $display("FAIL post_reset_fs got=%b exp=1", fs_a); end
            end
            if (pn == DC) begin
                checks++;
                if ({seg_a, enb_a} !== {7'b1001110, 4'b1110}) begin failures++; $display("FAIL post_reset_idx0 got=%b/%b exp=1001110/1110", seg_a, enb_a); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom;
                i_digits = r[15:0] >> (4 * $urandom_range(0, 4));
                i_dp = r[19:16];
                i_blink_mask = r[23:20];
                i_lz_sup = r[24];
            end
            if ($urandom_range(0, 59) == 0) i_en = ~i_en;
            tick();
            checks++;
            if (ovec() !== evec()) begin failures++; $display("FAIL random n=%0d en=%b got=%h exp=%h", pn, i_en, ovec(), evec()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_midframe();
        test_lz();
        test_blink();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
